// File: rtl/cic_decim_mc.sv
// cic_decim_mc: N-channel, S-stage CIC decimator with a runtime decimation
// ratio, decimation-dependent gain normalisation, and automatic flush plus
// output suppression while the comb history refills after reset or a rate
// change. All channels share one counter and one strobe so they stay aligned.
module cic_decim_mc #(
  parameter int CHANNELS  = 2,
  parameter int STAGES    = 5,
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 16,
  parameter int MAX_DECIM = 40
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [5:0]                    decimation,
  input  logic                          in_strobe,
  input  logic [CHANNELS*IN_WIDTH-1:0]  in_data,
  output logic                          out_strobe,
  output logic [CHANNELS*OUT_WIDTH-1:0] out_data,
  output logic                          settling
);

  localparam int ACC_WIDTH = IN_WIDTH + STAGES*$clog2(MAX_DECIM);
  localparam int DW        = $clog2(MAX_DECIM + 1);
  localparam int SW        = $clog2(STAGES + 1);
  localparam int GW        = $clog2(ACC_WIDTH + 1);

  // Smallest r with 2^r >= v; v never exceeds the 6-bit decimation range.
  function automatic int ceil_log2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 16; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Map 0/1 to 2 and anything above MAX_DECIM down to MAX_DECIM.
  function automatic logic [DW-1:0] clamp_decim(input logic [5:0] d);
    int v;
    v = int'(d);
    if (v < 2) v = 2;
    else if (v > MAX_DECIM) v = MAX_DECIM;
    return DW'(v);
  endfunction

  // Right shift that puts bit IN_WIDTH+G-1 of the comb output at the output MSB.
  function automatic logic [GW-1:0] right_shift_for(input logic [DW-1:0] d);
    int s;
    s = IN_WIDTH + STAGES*ceil_log2(int'(d)) - OUT_WIDTH;
    return (s > 0) ? GW'(s) : '0;
  endfunction

  // Left shift for the case where the output is wider than IN_WIDTH+G.
  function automatic logic [GW-1:0] left_shift_for(input logic [DW-1:0] d);
    int s;
    s = IN_WIDTH + STAGES*ceil_log2(int'(d)) - OUT_WIDTH;
    return (s < 0) ? GW'(-s) : '0;
  endfunction

  // Gain normalisation by bit selection: plain truncation, no rounding.
  function automatic logic signed [OUT_WIDTH-1:0] normalise(
    input logic signed [ACC_WIDTH-1:0] v,
    input logic        [GW-1:0]        rsh,
    input logic        [GW-1:0]        lsh
  );
    logic signed [ACC_WIDTH-1:0] t;
    t = (v >>> rsh) <<< lsh;
    return t[OUT_WIDTH-1:0];
  endfunction

  // Control state
  logic [DW-1:0] d_eff;
  logic [DW-1:0] d_new;
  logic [DW-1:0] cnt;
  logic          last_cnt;
  logic          rate_change;
  logic          clear;
  logic          emit;
  logic [GW-1:0] rsh_g;
  logic [GW-1:0] lsh_g;
  logic [SW-1:0] suppress;
  logic          settling_r;
  logic          vld_p0;
  logic          vld_p1;
  logic          vld_p2;

  // Datapath state
  logic signed [ACC_WIDTH-1:0] integ     [CHANNELS][STAGES];
  logic signed [ACC_WIDTH-1:0] integ_nxt [CHANNELS][STAGES];
  logic signed [ACC_WIDTH-1:0] integ_acc;
  logic signed [ACC_WIDTH-1:0] samp_p1   [CHANNELS];
  logic signed [ACC_WIDTH-1:0] dly       [CHANNELS][STAGES];
  logic signed [ACC_WIDTH-1:0] comb_tap  [CHANNELS][STAGES];
  logic signed [ACC_WIDTH-1:0] comb_out  [CHANNELS];
  logic signed [ACC_WIDTH-1:0] comb_acc;
  logic signed [OUT_WIDTH-1:0] out_p2    [CHANNELS];

  assign d_new       = clamp_decim(decimation);
  assign rate_change = (d_new != d_eff);
  assign clear       = reset || rate_change;
  assign last_cnt    = (cnt == d_eff - DW'(1));
  assign emit        = vld_p1 && (suppress == '0);

  // Shared control: rate latch, sample counter, valid pipeline, settling.
  always_ff @(posedge clock) begin
    if (clear) begin
      d_eff      <= d_new;
      rsh_g      <= right_shift_for(d_new);
      lsh_g      <= left_shift_for(d_new);
      cnt        <= '0;
      vld_p0     <= 1'b0;
      vld_p1     <= 1'b0;
      vld_p2     <= 1'b0;
      settling_r <= 1'b1;
      suppress   <= SW'(STAGES);
    end else begin
      vld_p0 <= in_strobe && last_cnt;
      if (in_strobe) cnt <= last_cnt ? '0 : cnt + DW'(1);
      vld_p1 <= vld_p0;
      vld_p2 <= emit;
      if (vld_p1) begin
        if (suppress != '0) suppress <= suppress - SW'(1);
        else settling_r <= 1'b0;
      end
    end
  end

  // ---- stage p0: integrator cascade, new sample enters all stages in one clock
  always_comb begin
    integ_acc = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      integ_acc = {{(ACC_WIDTH-IN_WIDTH){in_data[c*IN_WIDTH+IN_WIDTH-1]}},
                   in_data[c*IN_WIDTH +: IN_WIDTH]};
      for (int s = 0; s < STAGES; s++) begin
        integ_acc       = integ[c][s] + integ_acc;
        integ_nxt[c][s] = integ_acc;
      end
    end
  end

  // Integrators wrap modulo 2^ACC_WIDTH; the combs undo the wrap exactly.
  always_ff @(posedge clock) begin
    for (int c = 0; c < CHANNELS; c++) begin
      for (int s = 0; s < STAGES; s++) begin
        if (clear) integ[c][s] <= '0;
        else if (in_strobe) integ[c][s] <= integ_nxt[c][s];
      end
    end
  end

  // ---- stage p1: capture last integrator after the decimation strobe
  always_ff @(posedge clock) begin
    for (int c = 0; c < CHANNELS; c++) begin
      if (clear) samp_p1[c] <= '0;
      else if (vld_p0) samp_p1[c] <= integ[c][STAGES-1];
    end
  end

  // ---- stage p2: comb cascade (differential delay 1) and normalisation
  always_comb begin
    comb_acc = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      comb_acc = samp_p1[c];
      for (int s = 0; s < STAGES; s++) begin
        comb_tap[c][s] = comb_acc;
        comb_acc       = comb_acc - dly[c][s];
      end
      comb_out[c] = comb_acc;
    end
  end

  // Comb delays advance on every decimated result, suppressed or not.
  always_ff @(posedge clock) begin
    for (int c = 0; c < CHANNELS; c++) begin
      for (int s = 0; s < STAGES; s++) begin
        if (clear) dly[c][s] <= '0;
        else if (vld_p1) dly[c][s] <= comb_tap[c][s];
      end
    end
  end

  // Output registers: zeroed on reset, held across rate changes and suppression.
  always_ff @(posedge clock) begin
    for (int c = 0; c < CHANNELS; c++) begin
      if (reset) out_p2[c] <= '0;
      else if (!rate_change && emit) out_p2[c] <= normalise(comb_out[c], rsh_g, lsh_g);
    end
  end

  // Pack channel outputs onto the flat bus.
  always_comb begin
    out_data = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      out_data[c*OUT_WIDTH +: OUT_WIDTH] = out_p2[c];
    end
  end

  assign out_strobe = vld_p2;
  assign settling   = settling_r;

endmodule
